// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI serial-SRAM master.
package spi_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TRANSFER,
    FINISH,
    REST
  } spi_state_t;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  // Frame length: command byte, address, data word.
  function automatic int unsigned calc_nbits(input int unsigned addr_w,
                                             input int unsigned data_w);
    return 8 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Serial-in capture register. o_word includes the live serial bit so the full word is
// available on the same edge that samples its last bit.
module spi_shift_reg #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_si,
  output logic [W-1:0] o_word
);

  logic [W-2:0] r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= {r_q[W-3:0], i_si};
    end
  end

  assign o_word = {r_q, i_si};

endmodule

// File: rtl/spi_mem_ctrl.sv
// SPI mode-0 serial-SRAM master: one READ/WRITE command, address and data word per request,
// with read data landing atomically in inM_o or instruction_o.
module spi_mem_ctrl
  import spi_mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned SCLK_DIV = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              rwb_i,
  input  logic              sel_dest_i,
  input  logic [ADDR_W-1:0] address_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              si_i,
  output logic [DATA_W-1:0] inM_o,
  output logic [DATA_W-1:0] instruction_o,
  output logic              halt_o,
  output logic              done_o,
  output logic              so_o,
  output logic              sclk_o,
  output logic              csb_o
);

  localparam int unsigned NBITS = calc_nbits(ADDR_W, DATA_W);
  localparam int unsigned BitW  = $clog2(NBITS);
  localparam int unsigned DivW  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  if (SCLK_DIV < 1) begin : g_bad_div
    $error("SCLK_DIV must be at least 1");
  end
  if ((ADDR_W % 8) != 0) begin : g_bad_addr
    $error("ADDR_W must be a multiple of 8");
  end
  if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_data
    $error("DATA_W must be a multiple of 8 and at least 8");
  end

  spi_state_t        r_state, w_state_next;
  logic [BitW-1:0]   r_bit_cnt;
  logic [DivW-1:0]   r_div_cnt;
  logic              r_sclk, r_so, r_rwb, r_sel_dest;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data, r_inm, r_instr;
  logic [DATA_W-1:0] w_data_ser, w_shift_word, w_word;
  logic [NBITS-1:0]  w_frame;
  logic              w_first_bit, w_div_wrap, w_bit_end, w_last, w_sample;

  // Data bytes travel least-significant byte first; the same swap undoes it on receive.
  for (genvar gi = 0; gi < DATA_W / 8; gi++) begin : g_bytes
    assign w_data_ser[DATA_W-1-8*gi -: 8] = r_data[8*gi +: 8];
    assign w_word[8*gi +: 8]              = w_shift_word[DATA_W-1-8*gi -: 8];
  end

  assign w_frame     = {(r_rwb ? CMD_READ : CMD_WRITE), r_addr, w_data_ser};
  assign w_first_bit = rwb_i ? CMD_READ[7] : CMD_WRITE[7];
  assign w_div_wrap  = (r_div_cnt == DivW'(SCLK_DIV - 1));
  assign w_bit_end   = (r_state == TRANSFER) && w_div_wrap && r_sclk;
  assign w_last      = w_bit_end && (r_bit_cnt == '0);
  assign w_sample    = w_bit_end && r_rwb && (r_bit_cnt < BitW'(DATA_W));

  spi_shift_reg #(
    .W (DATA_W)
  ) u_shift (
    .i_clk  (clk),
    .i_rst  (reset),
    .i_en   (w_sample),
    .i_si   (si_i),
    .o_word (w_shift_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:     if (start_i) w_state_next = TRANSFER;
      TRANSFER: if (w_last) w_state_next = FINISH;
      FINISH:   w_state_next = start_i ? REST : IDLE;
      REST:     if (!start_i) w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  always_comb begin
    halt_o = 1'b0;
    csb_o  = 1'b1;
    done_o = 1'b0;
    case (r_state)
      IDLE:     halt_o = start_i;
      TRANSFER: begin
        halt_o = 1'b1;
        csb_o  = 1'b0;
      end
      FINISH:   done_o = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt  <= '0;
      r_div_cnt  <= '0;
      r_sclk     <= 1'b0;
      r_so       <= 1'b0;
      r_rwb      <= 1'b0;
      r_sel_dest <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_inm      <= '0;
      r_instr    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_div_cnt <= '0;
          r_bit_cnt <= '0;
          r_sclk    <= 1'b0;
          if (start_i) begin
            r_rwb      <= rwb_i;
            r_sel_dest <= sel_dest_i;
            r_addr     <= address_i;
            r_data     <= data_i;
            r_bit_cnt  <= BitW'(NBITS - 1);
            r_so       <= w_first_bit;
          end
        end
        TRANSFER: begin
          if (w_div_wrap) begin
            r_div_cnt <= '0;
            r_sclk    <= ~r_sclk;
            if (r_sclk) begin
              if (r_bit_cnt == '0) begin
                r_so <= 1'b0;
                if (r_rwb && r_sel_dest) r_inm <= w_word;
                if (r_rwb && !r_sel_dest) r_instr <= w_word;
              end else begin
                r_bit_cnt <= r_bit_cnt - 1'b1;
                r_so      <= w_frame[r_bit_cnt - 1'b1];
              end
            end
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        default: begin
          r_div_cnt <= '0;
          r_bit_cnt <= '0;
        end
      endcase
    end
  end

  assign sclk_o        = r_sclk;
  assign so_o          = r_so;
  assign inM_o         = r_inm;
  assign instruction_o = r_instr;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Bench for spi_mem_ctrl: timeline model plus SPI slave for the default build, and a directed
// check of a 24/8/1 build.
module tb_spi_mem_ctrl;

  localparam int unsigned AW   = 16;
  localparam int unsigned DW   = 16;
  localparam int unsigned DIV  = 2;
  localparam int unsigned NB   = 8 + AW + DW;
  localparam int unsigned TLEN = 2 * DIV * NB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_i = 1'b0, rwb_i = 1'b0, sel_dest_i = 1'b0, si_i = 1'b0;
  logic [AW-1:0] address_i = '0;
  logic [DW-1:0] data_i = '0;
  logic [DW-1:0] inM_o, instruction_o;
  logic          halt_o, done_o, so_o, sclk_o, csb_o;

  logic          start1 = 1'b0, rwb1 = 1'b0, sel1 = 1'b0, si1 = 1'b0;
  logic [23:0]   addr1 = '0;
  logic [7:0]    data1 = '0;
  logic [7:0]    inm1, instr1;
  logic          halt1, done1, so1, sclk1, csb1;

  spi_mem_ctrl u_dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start_i),
    .rwb_i         (rwb_i),
    .sel_dest_i    (sel_dest_i),
    .address_i     (address_i),
    .data_i        (data_i),
    .si_i          (si_i),
    .inM_o         (inM_o),
    .instruction_o (instruction_o),
    .halt_o        (halt_o),
    .done_o        (done_o),
    .so_o          (so_o),
    .sclk_o        (sclk_o),
    .csb_o         (csb_o)
  );

  spi_mem_ctrl #(
    .ADDR_W   (24),
    .DATA_W   (8),
    .SCLK_DIV (1)
  ) u_dut1 (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start1),
    .rwb_i         (rwb1),
    .sel_dest_i    (sel1),
    .address_i     (addr1),
    .data_i        (data1),
    .si_i          (si1),
    .inM_o         (inm1),
    .instruction_o (instr1),
    .halt_o        (halt1),
    .done_o        (done1),
    .so_o          (so1),
    .sclk_o        (sclk1),
    .csb_o         (csb1)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave response bytes (first received byte, second received byte) and model state.
  logic [7:0]    resp_b0 = '0, resp_b1 = '0;
  int            m_cnt;
  bit            m_done, m_hold, m_rwb, m_sel;
  logic [15:0]   m_addr, m_data, m_inm, m_instr;
  logic [NB-1:0] mosi_bits, last_frame;
  int            mosi_n, nrise, low_run, last_low_len, frames_done, sclk_rises, done_cnt;
  logic          csb_prev, sclk_prev;

  always @(negedge clk) begin
    logic [NB-1:0] exp_frame;
    logic [15:0]   w;
    logic          e_csb, e_sclk, e_halt, e_done;
    int            idx, j;
    if (reset) begin
      m_cnt = 0; m_done = 0; m_hold = 0; m_inm = '0; m_instr = '0;
      mosi_n = 0; nrise = 0; low_run = 0; csb_prev = 1'b1; sclk_prev = 1'b0; si_i = 1'b0;
    end else begin
      if (sclk_o && !sclk_prev) sclk_rises++;
      if (done_o) done_cnt++;
      if (!csb_o && sclk_o && !sclk_prev) begin
        mosi_bits = {mosi_bits[NB-2:0], so_o};
        mosi_n++;
        nrise++;
      end
      if (csb_o && !csb_prev) begin
        chk("mosi_bit_count", mosi_n, NB);
        exp_frame = {(m_rwb ? 8'h03 : 8'h02), m_addr, m_data[7:0], m_data[15:8]};
        chk("mosi_frame", mosi_bits, exp_frame);
        last_frame   = mosi_bits;
        last_low_len = low_run;
        frames_done++;
        mosi_n = 0;
        nrise  = 0;
      end
      if (!csb_o) begin
        if (csb_prev) low_run = 0;
        low_run++;
      end
      // MISO: hold the current bit through the whole high phase.
      idx  = nrise - (sclk_o ? 1 : 0);
      si_i = 1'b0;
      if (!csb_o && idx >= 8 + AW) begin
        j    = idx - (8 + AW);
        si_i = (j < 8) ? resp_b0[7-j] : resp_b1[15-j];
      end

      e_csb = 1'b1; e_sclk = 1'b0; e_halt = 1'b0; e_done = 1'b0;
      if (m_cnt > 0) begin
        e_csb  = 1'b0;
        e_sclk = ((m_cnt - 1) / DIV) % 2;
        e_halt = 1'b1;
      end else if (m_done) begin
        e_done = 1'b1;
      end else if (!m_hold) begin
        e_halt = start_i;
      end
      chk("csb", csb_o, e_csb);
      chk("sclk", sclk_o, e_sclk);
      chk("halt", halt_o, e_halt);
      chk("done", done_o, e_done);
      chk("inM", inM_o, m_inm);
      chk("instruction", instruction_o, m_instr);

      if (m_cnt > 0) begin
        if (m_cnt == TLEN) begin
          m_cnt  = 0;
          m_done = 1;
          if (m_rwb) begin
            w = {resp_b1, resp_b0};
            if (m_sel) m_inm = w;
            else m_instr = w;
          end
        end else begin
          m_cnt++;
        end
      end else if (m_done) begin
        m_done = 0;
        m_hold = start_i;
      end else if (m_hold) begin
        m_hold = start_i;
      end else if (start_i) begin
        m_cnt = 1; m_rwb = rwb_i; m_sel = sel_dest_i; m_addr = address_i; m_data = data_i;
      end
    end
    csb_prev  = reset ? 1'b1 : csb_o;
    sclk_prev = reset ? 1'b0 : sclk_o;
  end

  // Capture for the 24/8/1 instance.
  logic [63:0] c1_bits;
  int          c1_n, c1_low, c1_run, c1_stuck;
  logic        csb1_prev, sclk1_prev;

  always @(negedge clk) begin
    if (reset) begin
      c1_bits = '0; c1_n = 0; c1_low = 0; c1_run = 0; c1_stuck = 0;
      csb1_prev = 1'b1; sclk1_prev = 1'b0;
    end else begin
      if (!csb1) begin
        if (csb1_prev) c1_run = 0;
        c1_run++;
        c1_low++;
        if (c1_run > 1 && sclk1 === sclk1_prev) c1_stuck++;
        if (sclk1 && !sclk1_prev) begin
          c1_bits = {c1_bits[62:0], so1};
          c1_n++;
        end
      end
      csb1_prev  = csb1;
      sclk1_prev = sclk1;
    end
  end

  logic [15:0] fin_inm, fin_instr;
  logic        fin_halt;

  // Called at posedge+1; returns at posedge+1 with start_i low.
  task automatic request(input bit rwb, input bit sel, input logic [15:0] a,
                         input logic [15:0] d, input int hold);
    int n;
    start_i = 1'b1; rwb_i = rwb; sel_dest_i = sel; address_i = a; data_i = d;
    @(posedge clk); #1;
    rwb_i = 1'($urandom); sel_dest_i = 1'($urandom);
    address_i = 16'($urandom); data_i = 16'($urandom);
    n = 0;
    while (done_o !== 1'b1 && n < TLEN + 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_within_bound", done_o, 1);
    fin_inm = inM_o; fin_instr = instruction_o; fin_halt = halt_o;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    if (hold > 0) chk("rest_keeps_csb_high", csb_o, 1);
    start_i = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n, fd0, dc0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset.
    repeat (20) @(posedge clk);
    #1;
    chk("idle_csb", csb_o, 1);
    chk("idle_so", so_o, 0);
    chk("idle_halt", halt_o, 0);
    chk("idle_inM", inM_o, 0);
    chk("idle_sclk_rises", sclk_rises, 0);

    // Write 0x1234 <- 0xABCD.
    dc0 = done_cnt;
    request(1'b0, 1'b0, 16'h1234, 16'hABCD, 0);
    chk("wr_cmd_byte", last_frame[39:32], 8'h02);
    chk("wr_addr_hi", last_frame[31:24], 8'h12);
    chk("wr_addr_lo", last_frame[23:16], 8'h34);
    chk("wr_data_b0", last_frame[15:8], 8'hCD);
    chk("wr_data_b1", last_frame[7:0], 8'hAB);
    chk("wr_csb_low_cycles", last_low_len, 160);
    chk("wr_done_pulses", done_cnt - dc0, 1);
    chk("wr_regs_unchanged", {inM_o, instruction_o}, 32'h0);

    // Read into inM.
    resp_b0 = 8'h5A; resp_b1 = 8'hC3;
    request(1'b1, 1'b1, 16'h0010, 16'h0000, 0);
    chk("rd_inM_at_finish", fin_inm, 16'hC35A);
    chk("rd_instr_at_finish", fin_instr, 16'h0000);
    chk("rd_halt_at_finish", fin_halt, 0);
    chk("rd_cmd_byte", last_frame[39:32], 8'h03);
    chk("rd_addr", last_frame[31:16], 16'h0010);

    // Read into instruction with start held; no retrigger until released.
    resp_b0 = 8'h34; resp_b1 = 8'h12;
    fd0 = frames_done;
    request(1'b1, 1'b0, 16'h4321, 16'h0000, 10);
    chk("rd2_instr", fin_instr, 16'h1234);
    chk("rd2_inM_held", fin_inm, 16'hC35A);
    chk("held_start_single_frame", frames_done - fd0, 1);
    request(1'b0, 1'b1, 16'h0F0F, 16'h5555, 0);
    chk("restart_new_frame", frames_done - fd0, 2);

    // Reset in the middle of a read (around bit 17).
    resp_b0 = 8'hFF; resp_b1 = 8'hFF;
    start_i = 1'b1; rwb_i = 1'b1; sel_dest_i = 1'b1; address_i = 16'h0055;
    @(posedge clk);
    repeat (2 * DIV * 17 + 1) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("rst_csb", csb_o, 1);
    chk("rst_sclk", sclk_o, 0);
    chk("rst_so", so_o, 0);
    chk("rst_inM", inM_o, 0);
    chk("rst_instr", instruction_o, 0);
    start_i = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    resp_b0 = 8'hEF; resp_b1 = 8'hBE;
    request(1'b1, 1'b1, 16'h0200, 16'h0000, 0);
    chk("post_rst_read", fin_inm, 16'hBEEF);

    // Randomised traffic.
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
      resp_b0 = 8'($urandom); resp_b1 = 8'($urandom);
      request(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 3));
    end

    // 24-bit address, 8-bit data, SCLK_DIV=1 instance.
    start1 = 1'b1; rwb1 = 1'b0; sel1 = 1'b0; addr1 = 24'hABCDEF; data1 = 8'h77;
    @(posedge clk); #1;
    addr1 = '0; data1 = '0;
    n = 0;
    while (done1 !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_done", done1, 1);
    start1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_csb_low_cycles", c1_low, 80);
    chk("t6_bit_count", c1_n, 40);
    chk("t6_frame", c1_bits, 64'h02ABCDEF77);
    chk("t6_sclk_period", c1_stuck, 0);
    si1 = 1'b1; start1 = 1'b1; rwb1 = 1'b1; sel1 = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (done1 !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_read_inM", inm1, 8'hFF);
    chk("t6_read_instr", instr1, 8'h00);
    start1 = 1'b0;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/spi_mem_ctrl.md
Name: spi_mem_ctrl

Overview:
Parametrised SPI serial-SRAM master for the Hack CPU; successor to the fixed 16-bit SPI memory block.
- Issues one READ (0x03) or WRITE (0x02) command per request, followed by the address and one data word.
- Generates its own divided, SPI mode-0 serial clock.
- Read data is delivered atomically into one of two destination registers: data memory (inM) or instruction.
- Sits between the CPU core (start/halt handshake) and the external SPI SRAM.

Parameters:
ADDR_W, 16, address bits sent after the command byte; must be a multiple of 8.
DATA_W, 16, data word bits; must be a multiple of 8 and at least 8.
SCLK_DIV, 2, clk cycles per sclk half-period; must be at least 1; elaboration error otherwise.

Ports:
clk  in  1  system clock; all logic on its rising edge
reset  in  1  asynchronous, active-high reset
start_i  in  1  request level; a request is sampled in IDLE
rwb_i  in  1  1 = read, 0 = write
sel_dest_i  in  1  read destination: 1 = inM_o, 0 = instruction_o
address_i  in  ADDR_W  memory address
data_i  in  DATA_W  write data
si_i  in  1  SPI MISO
inM_o  out  DATA_W  last word read with sel_dest_i = 1
instruction_o  out  DATA_W  last word read with sel_dest_i = 0
halt_o  out  1  stall request to the CPU
done_o  out  1  one-cycle completion pulse
so_o  out  1  SPI MOSI
sclk_o  out  1  SPI clock, idles low
csb_o  out  1  SPI chip select, active low

Behaviour:
Interface and reset
- One clock (clk); reset is asynchronous and active-high.
- Reset values: state IDLE; csb_o=1; sclk_o=0; so_o=0; done_o=0; inM_o=0; instruction_o=0; all counters 0.
- Reset asserted mid-transfer aborts immediately. Same values apply; no partial update of inM_o or instruction_o.

Frame
- NBITS = 8 + ADDR_W + DATA_W; default 40.
- Frame = {cmd byte, address MSB-first, data bytes}.
- cmd byte = {7'b0000001, rwb}.
- Data bytes go in ascending byte order (byte0 = data[7:0] first); each byte is MSB-first.
- Read data is reassembled in the same order: first received byte becomes bits [7:0].

States (shared enum)
- IDLE: csb_o=1. If start_i=1 on an edge, latch address_i, data_i, rwb_i and sel_dest_i, then go to TRANSFER. Later changes to these inputs are ignored until the next request.
- TRANSFER: csb_o=0. Lasts exactly 2*SCLK_DIV*NBITS clk cycles (default 160).
  - Each bit: sclk_o low for SCLK_DIV cycles, then high for SCLK_DIV cycles.
  - so_o is registered and changes only at the start of a bit's low phase.
  - so_o holds bit NBITS-1 from the first TRANSFER cycle.
  - si_i is sampled on the clk edge that ends the last cycle of each high phase, and only for data-phase bits of a read.
  - After the last bit's high phase, go to FINISH.
- FINISH: one cycle. csb_o=1, sclk_o=0, done_o=1.
  - On entry, a read loads the selected destination register with the assembled word; the other register holds.
  - A write changes neither register.
  - Next state: IDLE if start_i=0, else REST.
- REST: csb_o=1. Wait for start_i=0, then IDLE. A held start_i never retriggers.

halt_o
- Combinational: (IDLE & start_i) | TRANSFER.
- Low in FINISH and REST, so the CPU advances in the completion cycle.

Counters
- bit_cnt counts down from NBITS-1 to 0.
- div_cnt counts 0..SCLK_DIV-1 and wraps.
- Both are cleared in IDLE.

Decomposition:
- Package spi_mem_pkg holds:
  - spi_state_t enum {IDLE, TRANSFER, FINISH, REST}
  - CMD_READ = 8'h03 and CMD_WRITE = 8'h02
  - a function computing NBITS
- Sub-module spi_shift_reg (parameter W, serial in, enable, parallel out) captures the read word.
- Sequencing, dividers and frame mux stay in spi_mem_ctrl.

Test Plan:
1. Reset, then idle for 20 cycles -> all outputs hold their reset values; sclk_o never toggles.
2. Write, default params, address 0x1234, data 0xABCD -> MOSI bytes 0x02, 0x12, 0x34, 0xCD, 0xAB. csb_o low for exactly 160 cycles. done_o high 1 cycle. inM_o and instruction_o unchanged.
3. Read, sel_dest_i=1, address 0x0010, slave returns 0x5A then 0xC3 -> cmd 0x03 sent. inM_o=0xC35A in the FINISH cycle. instruction_o unchanged. halt_o falls in the same cycle.
4. Read, sel_dest_i=0, slave returns 0x34 then 0x12 -> instruction_o=0x1234. start_i held high 10 more cycles -> stays in REST with no second frame. Drop then raise start_i -> new frame begins.
5. Reset asserted while transferring bit 17 of a read -> csb_o=1, sclk_o=0 and both data outputs 0 asynchronously. After release, a new request completes normally.
6. ADDR_W=24, DATA_W=8, SCLK_DIV=1, write address 0xABCDEF, data 0x77 -> 40 bits, 80-cycle TRANSFER, MOSI 0x02, 0xAB, 0xCD, 0xEF, 0x77, sclk_o period 2 clk cycles.
